// File: rtl/rom_arbiter_if.sv
// ---------------------------------------------------------------------------
// rom_arbiter_if
// Bus bundle between two ROM read requesters, the arbiter, and the program
// ROM.
//   A_* / B_*  : per-port request (REQ, LOCK, ADDR), grant (GNT) and
//                read return (DATA, VALID)
//   ROM_ADDR   : registered address to the ROM
//   ROM_DATA   : ROM registered output, one cycle after ROM_ADDR
// Modports:
//   slave  - arbiter view (requests and ROM data in; grants, returns and
//            ROM address out)
//   master - environment view (requesters plus ROM), the mirror of slave
// ---------------------------------------------------------------------------
interface rom_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              A_REQ;
    logic              A_LOCK;
    logic [ADDR_W-1:0] A_ADDR;
    logic              A_GNT;
    logic [DATA_W-1:0] A_DATA;
    logic              A_VALID;

    logic              B_REQ;
    logic              B_LOCK;
    logic [ADDR_W-1:0] B_ADDR;
    logic              B_GNT;
    logic [DATA_W-1:0] B_DATA;
    logic              B_VALID;

    logic [ADDR_W-1:0] ROM_ADDR;
    logic [DATA_W-1:0] ROM_DATA;

    modport slave (
        input  A_REQ, A_LOCK, A_ADDR,
        input  B_REQ, B_LOCK, B_ADDR,
        input  ROM_DATA,
        output A_GNT, A_DATA, A_VALID,
        output B_GNT, B_DATA, B_VALID,
        output ROM_ADDR
    );

    modport master (
        output A_REQ, A_LOCK, A_ADDR,
        output B_REQ, B_LOCK, B_ADDR,
        output ROM_DATA,
        input  A_GNT, A_DATA, A_VALID,
        input  B_GNT, B_DATA, B_VALID,
        input  ROM_ADDR
    );
endinterface

// File: rtl/rom_arbiter.sv
// ---------------------------------------------------------------------------
// rom_arbiter
// Shares a single-port synchronous program ROM between two requesters
// (A: instruction fetch, B: table reads). One address is accepted per cycle
// through a REQ/GNT handshake; the byte comes back to the issuing port two
// cycles after the grant edge. A port asserting LOCK with a grant keeps
// exclusive ownership until it transfers with LOCK=0 or idles with REQ=0 and
// LOCK=0.
//
// Ports:
//   CLK    - clock, rising edge
//   RESET  - asynchronous, active-high reset
//   bus    - rom_arbiter_if.slave (requests, grants, read returns, ROM bus)
//
// Build option:
//   ROM_ARB_RR_EN - when defined, an IDLE tie goes to the port not granted
//                   most recently; otherwise port A always wins a tie.
// ---------------------------------------------------------------------------
module rom_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic           CLK,
    input  logic           RESET,
    rom_arbiter_if.slave   bus
);
    localparam int NUM_PORTS = 2;
    localparam int STAGES    = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    state_t state_q;

    // Port index 0 = A, 1 = B.
    logic [NUM_PORTS-1:0]             req;
    logic [NUM_PORTS-1:0]             lock;
    logic [NUM_PORTS-1:0][ADDR_W-1:0] addr;
    logic [NUM_PORTS-1:0]             gnt;

    assign req  = {bus.B_REQ,  bus.A_REQ};
    assign lock = {bus.B_LOCK, bus.A_LOCK};
    assign addr = {bus.B_ADDR, bus.A_ADDR};

    // Tie-break selector: 1 means B wins a simultaneous IDLE request.
    logic tie_b;
`ifdef ROM_ARB_RR_EN
    logic favour_b_q;
    assign tie_b = favour_b_q;
`else
    assign tie_b = 1'b0;
`endif

    // Grant is purely a function of REQ/LOCK/state so a requester sees it in
    // the same cycle it asks.
    always_comb begin
        gnt = '0;
        unique case (state_q)
            OWN_A:   gnt[0] = req[0];
            OWN_B:   gnt[1] = req[1];
            default: begin
                if (&req) gnt = tie_b ? 2'b10 : 2'b01;
                else      gnt = req;
            end
        endcase
    end

    assign bus.A_GNT = gnt[0];
    assign bus.B_GNT = gnt[1];

    logic xfer;
    logic xsel;
    assign xfer = |gnt;
    assign xsel = gnt[1];

    logic [ADDR_W-1:0]              rom_addr_q;
    logic [STAGES-1:0]              vld_pipe_q;
    logic [STAGES-1:0]              port_pipe_q;
    logic [NUM_PORTS-1:0]           valid_q;
    logic [NUM_PORTS-1:0][DATA_W-1:0] data_q;

    // Ownership and ROM address.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            rom_addr_q <= '0;
        end else begin
            if (xfer) begin
                rom_addr_q <= addr[xsel];
                if (lock[xsel]) state_q <= xsel ? OWN_B : OWN_A;
                else            state_q <= IDLE;
            end else begin
                // Owner released ownership without issuing a read.
                if (state_q == OWN_A && !req[0] && !lock[0]) state_q <= IDLE;
                if (state_q == OWN_B && !req[1] && !lock[1]) state_q <= IDLE;
            end
        end
    end

`ifdef ROM_ARB_RR_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)     favour_b_q <= 1'b0;
        else if (xfer) favour_b_q <= ~xsel;
    end
`endif

    // Tag pipeline: stage 0 tracks the ROM address register, stage 1 tracks
    // the ROM output register. Reset clears the valids, so reads in flight
    // at reset never come back.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            vld_pipe_q  <= '0;
            port_pipe_q <= '0;
        end else begin
            vld_pipe_q  <= {vld_pipe_q[0],  xfer};
            port_pipe_q <= {port_pipe_q[0], xsel};
        end
    end

    // Per-port return registers; DATA holds until that port's next capture.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                valid_q[p] <= vld_pipe_q[STAGES-1] && (port_pipe_q[STAGES-1] == 1'(p));
                if (vld_pipe_q[STAGES-1] && (port_pipe_q[STAGES-1] == 1'(p)))
                    data_q[p] <= bus.ROM_DATA;
            end
        end
    end

    assign bus.ROM_ADDR = rom_addr_q;
    assign bus.A_VALID  = valid_q[0];
    assign bus.B_VALID  = valid_q[1];
    assign bus.A_DATA   = data_q[0];
    assign bus.B_DATA   = data_q[1];

endmodule
